// File: rtl/ov7670_sccb_sender.sv
// Purpose: walks an OV7670 register table and writes each {reg,value} entry to the camera as a 3-phase SCCB write.
// Latency: a frame takes 2+108+3 quarter-bits of bus time plus a 4-clock table settle gap; 16'hFFF0 idles the bus for DELAY_CYCLES.
// Backpressure: none; the table is stepped by advance/resend pulses and start is ignored while busy.
// Ports: clk, rst_n (synchronous, active-low); start; command/finished from the table; resend/advance back to
//        the table; sioc, siod_o/siod_oe/siod_i to the open-drain bus pads; busy/done/err status.
// Option: define SCCB_ACK_CHECK_EN to sample the three don't-care bits and flag a released-high line in err.
module ov7670_sccb_sender #(
  parameter int         CLK_FREQ     = 25_000_000,
  parameter int         SCCB_FREQ    = 100_000,
  parameter int         DELAY_CYCLES = 250_000,
  parameter logic [7:0] DEV_ADDR     = 8'h42
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] command,
  input  logic        finished,
  output logic        resend,
  output logic        advance,
  output logic        sioc,
  output logic        siod_o,
  output logic        siod_oe,
  input  logic        siod_i,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int QTR = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int DIV = CLK_FREQ / SCCB_FREQ;
  // Wide enough for a full SCCB period and for the bit index up to 27.
  localparam int CW  = ($clog2(DIV + 1) > 5) ? $clog2(DIV + 1) : 5;
  localparam int DW  = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES + 1) : 1;

  localparam logic [CW-1:0] ONE_C      = CW'(1);
  localparam logic [CW-1:0] QTR_LAST   = CW'(QTR - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(3);
  localparam logic [CW-1:0] LAST_BIT   = CW'(26);
  localparam logic [DW-1:0] ONE_D      = DW'(1);
  localparam logic [DW-1:0] DELAY_LAST = DW'(DELAY_CYCLES - 1);
  localparam logic [15:0]   CMD_DELAY  = 16'hFFF0;

  typedef enum logic [3:0] {
    IDLE, REWIND, LOAD, START, BITS, STOP, GAP, DELAY, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] qcnt;     // clocks within the current quarter (or settle wait)
  logic [1:0]    quarter;  // quarter index within START/BITS/STOP
  logic [CW-1:0] bit_cnt;  // 0-based index of the bit on the wire
  logic [DW-1:0] dcnt;
  logic [26:0]   frame;    // MSB is the bit currently on the wire

  // Bits 9, 18 and 27 of a 3-phase write are the don't-care (ACK) slots.
  function automatic logic dont_care(input logic [CW-1:0] b);
    return (b == CW'(8)) || (b == CW'(17)) || (b == CW'(26));
  endfunction

`ifdef SCCB_ACK_CHECK_EN
  logic err_q;
  assign err = err_q;
`else
  logic unused_siod_i;
  assign unused_siod_i = siod_i;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      qcnt    <= '0;
      quarter <= '0;
      bit_cnt <= '0;
      dcnt    <= '0;
      frame   <= '0;
      sioc    <= 1'b1;
      siod_o  <= 1'b1;
      siod_oe <= 1'b0;
      resend  <= 1'b0;
      advance <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      resend  <= 1'b0;
      advance <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= REWIND;
            qcnt   <= '0;
            resend <= 1'b1;
            busy   <= 1'b1;
            done   <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
            err_q  <= 1'b0;
`endif
          end
        end

        // Both waits cover the table's registered response to resend/advance.
        REWIND, GAP: begin
          if (qcnt == WAIT_LAST) begin
            qcnt  <= '0;
            state <= LOAD;
          end else begin
            qcnt <= qcnt + ONE_C;
          end
        end

        LOAD: begin
          qcnt    <= '0;
          quarter <= '0;
          bit_cnt <= '0;
          dcnt    <= '0;
          if (finished) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (command == CMD_DELAY) begin
            state <= DELAY;
          end else begin
            frame   <= {DEV_ADDR, 1'b1, command[15:8], 1'b1, command[7:0], 1'b1};
            state   <= START;
            // SIOD falls while SIOC is high: start condition.
            siod_oe <= 1'b1;
            siod_o  <= 1'b0;
          end
        end

        START: begin
          if (qcnt == QTR_LAST) begin
            qcnt <= '0;
            if (quarter == 2'd1) begin
              quarter <= '0;
              state   <= BITS;
              siod_o  <= frame[26];
              siod_oe <= 1'b1;
            end else begin
              quarter <= quarter + 2'd1;
              sioc    <= 1'b0;
            end
          end else begin
            qcnt <= qcnt + ONE_C;
          end
        end

        // Quarter 0: data settles with SIOC low; 1-2: SIOC high; 3: SIOC low.
        BITS: begin
          if (qcnt == QTR_LAST) begin
            qcnt <= '0;
`ifdef SCCB_ACK_CHECK_EN
            // End of quarter 1 is the middle of the SIOC-high phase.
            if (quarter == 2'd1 && dont_care(bit_cnt) && siod_i) err_q <= 1'b1;
`endif
            case (quarter)
              2'd0: begin
                sioc    <= 1'b1;
                quarter <= 2'd1;
              end
              2'd1: quarter <= 2'd2;
              2'd2: begin
                sioc    <= 1'b0;
                quarter <= 2'd3;
              end
              default: begin
                quarter <= '0;
                if (bit_cnt >= LAST_BIT) begin
                  state   <= STOP;
                  siod_oe <= 1'b1;
                  siod_o  <= 1'b0;
                end else begin
                  bit_cnt <= bit_cnt + ONE_C;
                  frame   <= {frame[25:0], 1'b0};
                  siod_o  <= frame[25];
                  siod_oe <= !dont_care(bit_cnt + ONE_C);
                end
              end
            endcase
          end else begin
            qcnt <= qcnt + ONE_C;
          end
        end

        STOP: begin
          if (qcnt == QTR_LAST) begin
            qcnt <= '0;
            case (quarter)
              2'd0: begin
                sioc    <= 1'b1;
                quarter <= 2'd1;
              end
              2'd1: begin
                siod_o  <= 1'b1;
                quarter <= 2'd2;
              end
              default: begin
                quarter <= '0;
                state   <= GAP;
                siod_oe <= 1'b0;
                advance <= 1'b1;
              end
            endcase
          end else begin
            qcnt <= qcnt + ONE_C;
          end
        end

        DELAY: begin
          if (dcnt == DELAY_LAST) begin
            dcnt    <= '0;
            qcnt    <= '0;
            state   <= GAP;
            advance <= 1'b1;
          end else begin
            dcnt <= dcnt + ONE_D;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_sender.sv
// Purpose: self-checking bench for ov7670_sccb_sender with a 2-cycle registered register-table model and a bus decoder.
// Latency: checks bit period, delay length and table stepping against values derived from the bench parameters.
// Backpressure: none; the bench drives start/siod_i and observes the bus and status outputs.
`timescale 1ns/1ps
module tb_ov7670_sccb_sender;

  localparam int CLK_FREQ     = 4_000_000;
  localparam int SCCB_FREQ    = 100_000;
  localparam int DELAY_CYCLES = 1000;
  localparam int BIT_CLKS     = 40;          // 4e6 / 1e5 clocks per SCCB bit
  localparam int TIMEOUT      = 20000;
  localparam logic [26:0] EXP_OE = 27'b111111110_111111110_111111110;
`ifdef SCCB_ACK_CHECK_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] command = 16'hFFFF;
  logic finished;
  logic siod_i;
  logic resend, advance, sioc, siod_o, siod_oe, busy, done, err;

  ov7670_sccb_sender #(
    .CLK_FREQ(CLK_FREQ), .SCCB_FREQ(SCCB_FREQ), .DELAY_CYCLES(DELAY_CYCLES), .DEV_ADDR(8'h42)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .command(command), .finished(finished),
    .resend(resend), .advance(advance), .sioc(sioc), .siod_o(siod_o), .siod_oe(siod_oe),
    .siod_i(siod_i), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Register table model: two registered stages between index and command.
  logic [15:0] tbl [8];
  int          tbl_idx = 0;
  logic [15:0] tbl_pipe = 16'hFFFF;
  always @(negedge clk) begin
    command = tbl_pipe;
    if (resend) tbl_idx = 0;
    else if (advance) tbl_idx = tbl_idx + 1;
    tbl_pipe = (tbl_idx < 8) ? tbl[tbl_idx] : 16'hFFFF;
  end
  assign finished = (command == 16'hFFFF);

  // Bus decoder: start/stop conditions, bits sampled on SIOC rising edges.
  int cyc = 0, nb = 0, starts = 0, stops = 0, falls = 0, advs = 0, resends = 0, glitches = 0;
  int first_fall = -1, first_adv = -1, pmin = 0, pmax = 0, last_rise = 0;
  bit in_frame = 1'b0;
  bit ack_inject = 1'b0;
  logic prev_sioc = 1'b1, prev_sda = 1'b1, mon_sda;
  logic [26:0] fbits, foe;
  logic [26:0] fr_q[$], oe_q[$];
  int nb_q[$], pmin_q[$], pmax_q[$];
  logic [15:0] exp_cmds[$];

  assign siod_i = ack_inject && in_frame && (nb == 18);

  always @(negedge clk) begin
    cyc = cyc + 1;
    mon_sda = siod_oe ? siod_o : 1'b1;
    if (advance) begin advs++; if (first_adv < 0) first_adv = cyc; end
    if (resend) resends++;
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (sioc && prev_sioc && mon_sda !== prev_sda) begin
        if (!mon_sda) begin
          if (in_frame) glitches++;
          starts++; in_frame = 1'b1; nb = 0; fbits = '0; foe = '0; pmin = 1 << 30; pmax = 0;
        end else if (in_frame) begin
          stops++; in_frame = 1'b0;
          fr_q.push_back(fbits); oe_q.push_back(foe); nb_q.push_back(nb);
          pmin_q.push_back(pmin); pmax_q.push_back(pmax);
        end
      end
      if (sioc && !prev_sioc && in_frame) begin
        if (nb < 27) begin
          fbits[26 - nb] = mon_sda;
          foe[26 - nb] = siod_oe;
          if (nb > 0) begin
            if (cyc - last_rise < pmin) pmin = cyc - last_rise;
            if (cyc - last_rise > pmax) pmax = cyc - last_rise;
          end
          last_rise = cyc;
        end
        nb++;
      end
      if (!sioc && prev_sioc) begin falls++; if (first_fall < 0) first_fall = cyc; end
    end
    prev_sioc = sioc;
    prev_sda = mon_sda;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_range(input string nm, input int val, input int lo, input int hi);
    checks++;
    if (val < lo || val > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, val, lo, hi);
    end
  endtask

  task automatic mon_clear();
    nb = 0; starts = 0; stops = 0; falls = 0; advs = 0; resends = 0; glitches = 0;
    first_fall = -1; first_adv = -1;
    fr_q.delete(); oe_q.delete(); nb_q.delete(); pmin_q.delete(); pmax_q.delete();
  endtask

  function automatic logic [26:0] exp_frame(input logic [15:0] c);
    return {8'h42, 1'b1, c[15:8], 1'b1, c[7:0], 1'b1};
  endfunction

  task automatic load_tbl(input int n, input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2);
    for (int i = 0; i < 8; i++) tbl[i] = 16'hFFFF;
    if (n > 0) tbl[0] = c0;
    if (n > 1) tbl[1] = c1;
    if (n > 2) tbl[2] = c2;
  endtask

  // Reference: entries before the 16'hFFFF marker each earn one advance;
  // every entry other than the delay marker becomes one write frame.
  task automatic model(output int ea);
    exp_cmds.delete();
    ea = 0;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i] == 16'hFFFF) break;
      ea++;
      if (tbl[i] != 16'hFFF0) exp_cmds.push_back(tbl[i]);
    end
  endtask

  task automatic pulse_start(output int t0);
    @(posedge clk); #1;
    mon_clear();
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check("start busy", busy, 1);
    check("start clears done", done, 0);
    check("start clears err", err, 0);
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (!done && k < TIMEOUT) begin @(posedge clk); #1; k++; end
    check({nm, " done reached"}, done, 1);
  endtask

  task automatic wait_nb(input string nm, input int n);
    int k;
    k = 0;
    while (nb < n && k < TIMEOUT) begin @(posedge clk); #1; k++; end
    check({nm, " bits seen"}, (nb >= n), 1);
  endtask

  task automatic check_run(input string nm, input int ef, input int ea, input logic exp_err);
    check({nm, " busy"}, busy, 0);
    check({nm, " err"}, err, exp_err);
    check({nm, " frames"}, fr_q.size(), ef);
    check({nm, " advances"}, advs, ea);
    check({nm, " resends"}, resends, 1);
    check({nm, " sioc falls"}, falls, 28 * ef);
    check({nm, " glitches"}, glitches, 0);
    for (int j = 0; j < fr_q.size() && j < exp_cmds.size(); j++) begin
      check({nm, " frame bits"}, fr_q[j], exp_frame(exp_cmds[j]));
      check({nm, " frame oe"}, oe_q[j], EXP_OE);
      check({nm, " frame rises"}, nb_q[j], 28);
      check({nm, " period min"}, pmin_q[j], BIT_CLKS);
      check({nm, " period max"}, pmax_q[j], BIT_CLKS);
    end
  endtask

  typedef struct {
    int n;
    logic [15:0] c0, c1, c2;
    int ef;
    int ea;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int t0, ea, n;
    logic [15:0] c[3];

    vecs[0] = '{1, 16'h1280, 16'hFFFF, 16'hFFFF, 1, 1};
    vecs[1] = '{3, 16'h1280, 16'h1100, 16'h3A04, 3, 3};
    vecs[2] = '{0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0};
    vecs[3] = '{2, 16'hFFF0, 16'h1280, 16'hFFFF, 1, 2};
    load_tbl(0, 16'hFFFF, 16'hFFFF, 16'hFFFF);

    // Reset values, then ten idle clocks.
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {sioc, siod_o, siod_oe, resend, advance, busy, done, err}, 8'b1100_0000);
    rst_n = 1'b1;
    mon_clear();
    repeat (10) begin @(posedge clk); #1; end
    check("idle outputs", {sioc, siod_oe, busy, done}, 4'b1000);
    check("idle no advance", advs, 0);

    // Table-driven sequences.
    for (int v = 0; v < 4; v++) begin
      load_tbl(vecs[v].n, vecs[v].c0, vecs[v].c1, vecs[v].c2);
      model(ea);
      pulse_start(t0);
      wait_done($sformatf("vec%0d", v));
      check_run($sformatf("vec%0d", v), vecs[v].ef, vecs[v].ea, 1'b0);
      if (vecs[v].c0 == 16'hFFF0) begin
        check_range("delay length", first_adv - t0, DELAY_CYCLES, DELAY_CYCLES + 10);
        check("delay quiet bus", (first_fall > first_adv), 1);
      end
    end

    // start while busy is ignored.
    load_tbl(2, 16'h1280, 16'h1100, 16'hFFFF);
    model(ea);
    pulse_start(t0);
    wait_nb("busy start", 5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy start");
    check_run("busy start", 2, 2, 1'b0);

    // Reset during bit 12 abandons the frame.
    load_tbl(1, 16'h1280, 16'hFFFF, 16'hFFFF);
    pulse_start(t0);
    wait_nb("midreset", 12);
    while (sioc) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset outputs", {sioc, siod_oe, busy, done, advance, resend}, 6'b100000);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("midreset no advance", advs, 0);
    check("midreset no stop", stops, 0);
    check("midreset idle", {sioc, siod_oe, busy}, 3'b100);

    // High level on the bit-18 don't-care slot.
    load_tbl(1, 16'h1280, 16'hFFFF, 16'hFFFF);
    model(ea);
    ack_inject = 1'b1;
    pulse_start(t0);
    wait_nb("ack", 19);
    check("ack err after bit 18", err, ACK_EN);
    wait_done("ack");
    check_run("ack", 1, 1, ACK_EN);
    ack_inject = 1'b0;
    pulse_start(t0);
    wait_done("ack restart");
    check_run("ack restart", 1, 1, 1'b0);

    // Randomized tables against the reference model.
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < 3; i++) begin
        c[i] = 16'($urandom);
        if (c[i][15:4] == 12'hFFF) c[i][15] = 1'b0;
        if ($urandom_range(0, 5) == 0) c[i] = 16'hFFF0;
      end
      load_tbl(n, c[0], c[1], c[2]);
      model(ea);
      pulse_start(t0);
      wait_done($sformatf("rand%0d", r));
      check_run($sformatf("rand%0d", r), exp_cmds.size(), ea, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
